// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths and FSM encoding for the ALU register-file sequencer
package alu_seq_pkg;
    localparam int DW    = 16;
    localparam int FLAGW = 4;
    localparam int NREGS = 8;
    localparam int RAW   = 3;
    localparam int CNTW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;
endpackage

// File: rtl/alu_regfile_sequencer_if.sv
// rtl/alu_regfile_sequencer_if.sv - command, host register port, debug read and external ALU bundle
interface alu_regfile_sequencer_if;
    import alu_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [DW-1:0]    cmd_op;
    logic [RAW-1:0]   cmd_rs1;
    logic [RAW-1:0]   cmd_rs2;
    logic [RAW-1:0]   cmd_rd;
    logic             cmd_imm_en;
    logic [DW-1:0]    cmd_imm;
    logic             wr_en;
    logic [RAW-1:0]   wr_addr;
    logic [DW-1:0]    wr_data;
    logic [RAW-1:0]   rd_addr;
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic [DW-1:0]    alu_op;
    logic [DW-1:0]    alu_c;
    logic [FLAGW-1:0] alu_flags;
    logic             done;
    logic [FLAGW-1:0] flags_q;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm_en, cmd_imm,
        input  wr_en, wr_addr, wr_data, rd_addr, alu_c, alu_flags,
        output cmd_ready, rd_data, alu_a, alu_b, alu_op, done, flags_q
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm_en, cmd_imm,
        output wr_en, wr_addr, wr_data, rd_addr, alu_c, alu_flags,
        input  cmd_ready, rd_data, alu_a, alu_b, alu_op, done, flags_q
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 8x16 register file, two operand reads, debug read, WB-over-host write
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [RAW-1:0] rs1_addr_i,
    input  logic [RAW-1:0] rs2_addr_i,
    input  logic [RAW-1:0] dbg_addr_i,
    output logic [DW-1:0]  rs1_data_o,
    output logic [DW-1:0]  rs2_data_o,
    output logic [DW-1:0]  dbg_data_o,
    input  logic           wb_en_i,
    input  logic [RAW-1:0] wb_addr_i,
    input  logic [DW-1:0]  wb_data_i,
    input  logic           host_en_i,
    input  logic [RAW-1:0] host_addr_i,
    input  logic [DW-1:0]  host_data_i
);
    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    assign rs1_data_o = regs_q[rs1_addr_i];
    assign rs2_data_o = regs_q[rs2_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

    // Writeback is applied last so it overrides a host write to the same register.
    always_comb begin
        regs_d = regs_q;
        if (host_en_i) regs_d[host_addr_i] = host_data_i;
        if (wb_en_i)   regs_d[wb_addr_i]   = wb_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end
endmodule

// File: rtl/alu_regfile_sequencer.sv
// rtl/alu_regfile_sequencer.sv - issues one register-file command to an external ALU and writes back
module alu_regfile_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    alu_regfile_sequencer_if.slave bus_if
);
    state_e           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [RAW-1:0]   rd_q;
    logic [DW-1:0]    alu_a_q;
    logic [DW-1:0]    alu_b_q;
    logic [DW-1:0]    alu_op_q;
    logic [FLAGW-1:0] flags_q;
    logic             done_q;
    logic [DW-1:0]    rs1_data;
    logic [DW-1:0]    rs2_data;

    assign bus_if.cmd_ready = (state_q == ST_IDLE);
    assign bus_if.alu_a     = alu_a_q;
    assign bus_if.alu_b     = alu_b_q;
    assign bus_if.alu_op    = alu_op_q;
    assign bus_if.flags_q   = flags_q;
    assign bus_if.done      = done_q;

    alu_seq_regfile u_regfile (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rs1_addr_i  (bus_if.cmd_rs1),
        .rs2_addr_i  (bus_if.cmd_rs2),
        .dbg_addr_i  (bus_if.rd_addr),
        .rs1_data_o  (rs1_data),
        .rs2_data_o  (rs2_data),
        .dbg_data_o  (bus_if.rd_data),
        .wb_en_i     (state_q == ST_WB),
        .wb_addr_i   (rd_q),
        .wb_data_i   (bus_if.alu_c),
        .host_en_i   (bus_if.wr_en),
        .host_addr_i (bus_if.wr_addr),
        .host_data_i (bus_if.wr_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.cmd_valid) begin
                        alu_a_q  <= rs1_data;
                        alu_b_q  <= bus_if.cmd_imm_en ? bus_if.cmd_imm : rs2_data;
                        alu_op_q <= bus_if.cmd_op;
                        rd_q     <= bus_if.cmd_rd;
                        cnt_q    <= CNTW'(ALU_LATENCY);
                        state_q  <= ST_EXEC;
                    end
                end
                // Operands stay frozen here; the counter only times the ALU pipeline.
                ST_EXEC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) state_q <= ST_WB;
                end
                ST_WB: begin
                    flags_q <= bus_if.alu_flags;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// tb/tb_alu_regfile_sequencer.sv - directed self-checking bench with a registered one-cycle adder ALU
module tb_alu_regfile_sequencer;
    logic clk_i;
    logic rst_ni;
    int   n_checks;
    int   n_fail;

    alu_regfile_sequencer_if bus ();

    alu_regfile_sequencer #(.ALU_LATENCY(1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus_if (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // External ALU: registered add for every op; flags[0]=zero, flags[1]=carry.
    logic [16:0] sum;
    assign sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    always @(posedge clk_i) begin
        bus.alu_c     <= sum[15:0];
        bus.alu_flags <= {2'b00, sum[16], (sum[15:0] == 16'h0000)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reg_check(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        bus.rd_addr = addr;
        #1;
        check(tag, {16'h0, bus.rd_data}, {16'h0, exp});
    endtask

    task automatic host_wr(input logic [2:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic set_cmd(input logic [15:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic ie, input logic [15:0] imm);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_rs1    = rs1;
        bus.cmd_rs2    = rs2;
        bus.cmd_rd     = rd;
        bus.cmd_imm_en = ie;
        bus.cmd_imm    = imm;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_ni   = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
        bus.cmd_rd = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;

        // Reset held for two cycles
        cyc(); cyc();
        check("rst_alu_a", {16'h0, bus.alu_a}, 32'h0);
        check("rst_alu_b", {16'h0, bus.alu_b}, 32'h0);
        check("rst_alu_op", {16'h0, bus.alu_op}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_flags", {28'h0, bus.flags_q}, 32'h0);
        for (int i = 0; i < 8; i++) reg_check($sformatf("rst_r%0d", i), 3'(i), 16'h0000);
        rst_ni = 1'b1;
        cyc();
        check("rst_ready", {31'h0, bus.cmd_ready}, 32'h1);

        // 0x00FF + 0x0001 -> R3
        host_wr(3'd1, 16'h00FF);
        host_wr(3'd2, 16'h0001);
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0);
        check("t1_ready_T", {31'h0, bus.cmd_ready}, 32'h1);
        cyc(); bus.cmd_valid = 1'b0;
        check("t1_alu_a", {16'h0, bus.alu_a}, 32'h00FF);
        check("t1_alu_b", {16'h0, bus.alu_b}, 32'h0001);
        check("t1_alu_op", {16'h0, bus.alu_op}, 32'h0000);
        check("t1_ready_T1", {31'h0, bus.cmd_ready}, 32'h0);
        check("t1_done_T1", {31'h0, bus.done}, 32'h0);
        cyc();
        check("t1_ready_T2", {31'h0, bus.cmd_ready}, 32'h0);
        check("t1_done_T2", {31'h0, bus.done}, 32'h0);
        check("t1_alu_a_hold", {16'h0, bus.alu_a}, 32'h00FF);
        cyc();
        check("t1_done_T3", {31'h0, bus.done}, 32'h1);
        check("t1_ready_T3", {31'h0, bus.cmd_ready}, 32'h1);
        check("t1_flags", {28'h0, bus.flags_q}, 32'h0);
        reg_check("t1_r3", 3'd3, 16'h0100);
        cyc();
        check("t1_done_T4", {31'h0, bus.done}, 32'h0);
        check("t1_flags_hold", {28'h0, bus.flags_q}, 32'h0);

        // Immediate operand: 0x0001 + 0xFFFF -> R4 = 0, zero and carry
        host_wr(3'd1, 16'h0001);
        host_wr(3'd4, 16'h7777);
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd4, 1'b1, 16'hFFFF);
        cyc(); bus.cmd_valid = 1'b0;
        check("t2_alu_a", {16'h0, bus.alu_a}, 32'h0001);
        check("t2_alu_b", {16'h0, bus.alu_b}, 32'hFFFF);
        cyc(); cyc();
        check("t2_done", {31'h0, bus.done}, 32'h1);
        check("t2_flags", {28'h0, bus.flags_q}, 32'h3);
        reg_check("t2_r4", 3'd4, 16'h0000);
        cyc();

        // Back-to-back dependent commands with cmd_valid held
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd5, 1'b0, 16'h0);
        cyc();
        check("t3_ready_a1", {31'h0, bus.cmd_ready}, 32'h0);
        set_cmd(16'hA5C3, 3'd5, 3'd2, 3'd6, 1'b0, 16'h0);
        cyc();
        check("t3_ready_a2", {31'h0, bus.cmd_ready}, 32'h0);
        cyc();
        check("t3_done_a", {31'h0, bus.done}, 32'h1);
        check("t3_ready_a3", {31'h0, bus.cmd_ready}, 32'h1);
        reg_check("t3_r5", 3'd5, 16'h0002);
        cyc(); bus.cmd_valid = 1'b0;
        check("t3_alu_a_b", {16'h0, bus.alu_a}, 32'h0002);
        check("t3_alu_op_b", {16'h0, bus.alu_op}, 32'hA5C3);
        check("t3_ready_b1", {31'h0, bus.cmd_ready}, 32'h0);
        check("t3_done_b1", {31'h0, bus.done}, 32'h0);
        cyc();
        check("t3_ready_b2", {31'h0, bus.cmd_ready}, 32'h0);
        cyc();
        check("t3_done_b", {31'h0, bus.done}, 32'h1);
        reg_check("t3_r6", 3'd6, 16'h0003);
        cyc();

        // Host write to rs1 in the accept cycle is not seen by the command
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd7, 1'b0, 16'h0);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 16'h0100;
        cyc(); bus.cmd_valid = 1'b0; bus.wr_en = 1'b0;
        check("t4_alu_a", {16'h0, bus.alu_a}, 32'h0001);
        reg_check("t4_r1", 3'd1, 16'h0100);
        cyc(); cyc();
        reg_check("t4_r7", 3'd7, 16'h0002);
        cyc();

        // Host write colliding with writeback: same address, then different address
        host_wr(3'd1, 16'h0001);
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0);
        cyc(); bus.cmd_valid = 1'b0;
        cyc();
        host_wr(3'd3, 16'h1234);
        check("t5_done_same", {31'h0, bus.done}, 32'h1);
        reg_check("t5_r3_wb_wins", 3'd3, 16'h0002);
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0010);
        cyc(); bus.cmd_valid = 1'b0;
        cyc();
        host_wr(3'd5, 16'h1234);
        reg_check("t5_r3_wb", 3'd3, 16'h0011);
        reg_check("t5_r5_host", 3'd5, 16'h1234);
        cyc();

        // Reset during EXEC discards the in-flight command
        set_cmd(16'h0000, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0);
        cyc(); bus.cmd_valid = 1'b0;
        check("t6_ready_exec", {31'h0, bus.cmd_ready}, 32'h0);
        rst_ni = 1'b0;
        #1;
        check("t6_ready_in_rst", {31'h0, bus.cmd_ready}, 32'h1);
        cyc();
        rst_ni = 1'b1;
        cyc();
        check("t6_ready_after", {31'h0, bus.cmd_ready}, 32'h1);
        check("t6_done_0", {31'h0, bus.done}, 32'h0);
        reg_check("t6_r6", 3'd6, 16'h0000);
        cyc();
        check("t6_done_1", {31'h0, bus.done}, 32'h0);
        reg_check("t6_r6_late", 3'd6, 16'h0000);
        check("t6_alu_a", {16'h0, bus.alu_a}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_regfile_sequencer.md
ALU_REGFILE_SEQUENCER -- requirements
Module: alu_regfile_sequencer

Interface
REQ-001 Parameter: ALU_LATENCY, 1, cycles from ALU inputs stable to alu_c/alu_flags valid (legal 1..7).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready.
REQ-006 cmd_op  in  16  ALU operation code, forwarded unchanged.
REQ-007 cmd_rs1, cmd_rs2, cmd_rd  in  3 each  source A, source B, destination register index.
REQ-008 cmd_imm_en  in  1  when 1, operand B = cmd_imm instead of R[cmd_rs2].
REQ-009 cmd_imm  in  16  immediate operand B.
REQ-010 wr_en, wr_addr(3), wr_data(16)  in  host register load port.
REQ-011 rd_addr  in  3; rd_data  out  16  combinational debug read of R[rd_addr].
REQ-012 alu_a, alu_b, alu_op  out  16 each  registered ALU operands/opcode.
REQ-013 alu_c  in  16; alu_flags  in  4  ALU result and flags.
REQ-014 done  out  1  one-cycle pulse: writeback complete.
REQ-015 flags_q  out  4  flags of last completed command.

Function
REQ-016 Register file SHALL be 8 x 16-bit, R0 not hardwired.
REQ-017 FSM states SHALL be IDLE, EXEC, WB; cmd_ready=1 only in IDLE.
REQ-018 IDLE, accept in cycle T: alu_a<=R[rs1], alu_b<=(imm_en ? cmd_imm : R[rs2]), alu_op<=cmd_op, rd latched, counter<=ALU_LATENCY; ->EXEC.
REQ-019 EXEC SHALL last exactly ALU_LATENCY cycles (T+1..T+L), alu_a/alu_b/alu_op held stable; ->WB.
REQ-020 WB (cycle T+1+L): at its closing edge R[rd]<=alu_c, flags_q<=alu_flags, done<=1; ->IDLE.
REQ-021 done SHALL be high in cycle T+2+L only; new R[rd] and cmd_ready=1 visible that same cycle (accept-to-done L+2 cycles; max throughput one command per L+2 cycles).
REQ-022 Operands SHALL be read at the accept edge; a host write in the accept cycle to rs1/rs2 is not seen by that command.
REQ-023 Host write and WB write to the same cycle: WB SHALL win for same address; different addresses both commit.
REQ-024 Host writes SHALL be honoured in every state.
REQ-025 alu_a/alu_b/alu_op SHALL retain last values in IDLE; flags_q retained until next WB.
REQ-026 No arithmetic in this block; widths pass through unchanged.

Reset
REQ-027 reset low SHALL immediately force state IDLE, all R[i]=0, alu_a=alu_b=alu_op=0, flags_q=0, done=0, counter=0.
REQ-028 Reset in EXEC/WB SHALL discard the in-flight command: no writeback, no done pulse.
REQ-029 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Package alu_seq_pkg SHALL hold DW=16, FLAGW=4, NREGS=8, RAW=3 and the FSM state encoding.
REQ-031 One sub-module alu_seq_regfile: 8x16, two operand read ports, one debug read port, one write port with WB-over-host priority mux.

Verification (bench ALU model: registered, L=1, op 0 -> c=a+b mod 2^16, flags[0]=zero, flags[1]=carry)
REQ-032 Reset held low 2 cycles -> all outputs 0, rd_data=0 for addresses 0..7, cmd_ready=1 after release.
REQ-033 Load R1=0x00FF, R2=0x0001; cmd op=0 rs1=1 rs2=2 rd=3 at T -> alu_a=0x00FF, alu_b=0x0001 at T+1, done at T+3, R3=0x0100, flags_q=4'b0000.
REQ-034 R1=0x0001, imm_en=1, imm=0xFFFF, rd=4 -> alu_b=0xFFFF, R4=0x0000, flags_q=4'b0011.
REQ-035 cmd_valid held with two dependent commands (second rs1=first rd) -> second accepted in first's done cycle, uses new value; cmd_ready low exactly 2 cycles per command.
REQ-036 Host write wr_addr=3 wr_data=0x1234 in WB cycle of rd=3 command -> R3=ALU result; write to wr_addr=5 same cycle -> R5=0x1234.
REQ-037 Reset asserted during EXEC -> no done pulse, R[rd]=0, state IDLE, cmd_ready=1 after release.
